// File: rtl/sd_serializer.sv
// ---------------------------------------------------------------------------
// sd_serializer
//
// Parallel-to-serial front end for the sequence-detector chain. Words arrive
// over a valid/ready handshake and are emitted one bit per clock on a
// registered serial output. A one-word holding buffer lets consecutive words
// stream with no idle bit between them.
//
// Parameters:
//   WIDTH      bits per word (2 or more)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//   IDLE_BIT   value driven on sout while no word is being sent
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    word to serialize, sampled only on the accept edge
//   in_valid   in_data is valid this cycle
//   in_ready   a word can be accepted this cycle (combinational)
//   sout       registered serial bit, drives the detector din
//   bit_valid  registered, sout carries a data bit
//   word_done  registered, high together with the last bit of each word
//   busy       registered, a word is shifting or held
// ---------------------------------------------------------------------------
module sd_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             bit_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_hold;
   logic             r_holdFull;
   logic             r_sout;
   logic             r_bitValid;
   logic             r_wordDone;
   logic             r_busy;

   state_t           w_state;
   logic [WIDTH-1:0] w_shift;
   logic [CW-1:0]    w_count;
   logic [WIDTH-1:0] w_hold;
   logic             w_holdFull;
   logic             w_sout;
   logic             w_bitValid;
   logic             w_wordDone;
   logic             w_busy;

   logic             w_accept;
   logic             w_lastBit;
   logic             w_shifterFree;
   logic             w_loadFromHold;
   logic             w_loadDirect;
   logic             w_load;
   logic             w_toHold;
   logic [WIDTH-1:0] w_loadWord;
   logic [WIDTH-1:0] w_advWord;

   // Bit that goes on the wire first for a word sitting in the shifter.
   function automatic logic firstBit(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? word[WIDTH-1] : word[0];
   endfunction

   // Shifter contents after the presented bit has been consumed.
   function automatic logic [WIDTH-1:0] advanceWord(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
   endfunction

   // Ready only depends on the holding buffer; space freed this cycle is not
   // passed through, which keeps in_ready free of any path from in_valid.
   assign in_ready = !r_holdFull && !reset;

   // r_count holds the number of bits still to come after the one on sout,
   // so zero in SHIFT means the last bit is being presented right now.
   assign w_accept       = in_valid && in_ready;
   assign w_lastBit      = (r_state == ST_SHIFT) && (r_count == '0);
   assign w_shifterFree  = (r_state == ST_IDLE) || w_lastBit;
   assign w_loadFromHold = w_lastBit && r_holdFull;
   assign w_loadDirect   = w_accept && w_shifterFree;
   assign w_toHold       = w_accept && !w_shifterFree;
   assign w_load         = w_loadFromHold || w_loadDirect;
   assign w_loadWord     = w_loadFromHold ? r_hold : in_data;
   assign w_advWord      = advanceWord(r_shift);

   // State register plus every registered output; all of them follow the
   // next-state values so reset forces the idle picture immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_count    <= '0;
         r_hold     <= '0;
         r_holdFull <= 1'b0;
         r_sout     <= IDLE_BIT;
         r_bitValid <= 1'b0;
         r_wordDone <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_shift    <= w_shift;
         r_count    <= w_count;
         r_hold     <= w_hold;
         r_holdFull <= w_holdFull;
         r_sout     <= w_sout;
         r_bitValid <= w_bitValid;
         r_wordDone <= w_wordDone;
         r_busy     <= w_busy;
      end
   end

   // Next-state logic. A load (from hold or directly from the input) takes
   // priority and restarts the shifter with the new word's first bit, which
   // is what lets words chain with no gap. The held word always wins over the
   // input at the last bit because in_ready is low while hold is full.
   always_comb begin
      w_state    = r_state;
      w_shift    = r_shift;
      w_count    = r_count;
      w_hold     = r_hold;
      w_holdFull = r_holdFull;
      w_sout     = r_sout;
      w_bitValid = r_bitValid;
      w_wordDone = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_load) begin
               w_state    = ST_SHIFT;
               w_shift    = w_loadWord;
               w_sout     = firstBit(w_loadWord);
               w_count    = CW'(WIDTH - 1);
               w_bitValid = 1'b1;
            end else begin
               w_sout     = IDLE_BIT;
               w_bitValid = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (w_load) begin
               w_shift    = w_loadWord;
               w_sout     = firstBit(w_loadWord);
               w_count    = CW'(WIDTH - 1);
               w_bitValid = 1'b1;
            end else if (!w_lastBit) begin
               w_shift    = w_advWord;
               w_sout     = firstBit(w_advWord);
               w_count    = r_count - CW'(1);
               w_bitValid = 1'b1;
               w_wordDone = (r_count == CW'(1));
            end else begin
               w_state    = ST_IDLE;
               w_sout     = IDLE_BIT;
               w_bitValid = 1'b0;
            end
         end
         default: begin
            w_state    = ST_IDLE;
            w_sout     = IDLE_BIT;
            w_bitValid = 1'b0;
         end
      endcase

      if (w_loadFromHold) begin
         w_holdFull = 1'b0;
      end
      if (w_toHold) begin
         w_hold     = in_data;
         w_holdFull = 1'b1;
      end

      w_busy = w_bitValid || w_holdFull;
   end

   assign sout      = r_sout;
   assign bit_valid = r_bitValid;
   assign word_done = r_wordDone;
   assign busy      = r_busy;

endmodule
